// File: rtl/bus_dbg_master_pkg.sv
// Shared definitions for the serial debug bus initiator: SoC bus field layout,
// debug protocol byte codes and engine state encoding.
package bus_dbg_master_pkg;

  // Initiator side of the SoC bus
  localparam int BUS_FIELD_CLK     = 0;
  localparam int BUS_FIELD_RESET_L = 1;
  localparam int BUS_FIELD_ADDR    = 2;
  localparam int BUS_ADDR_W        = 32;
  localparam int BUS_FIELD_WR_DATA = 34;
  localparam int BUS_DATA_W        = 32;
  localparam int BUS_FIELD_BE      = 66;
  localparam int BUS_BE_W          = 4;
  localparam int BUS_FIELD_RE      = 70;
  localparam int BUS_FIELD_WE      = 71;
  localparam int BUS_IN_WIDTH      = 72;

  // Responder side (OR of all responders)
  localparam int BUS_FIELD_RD_DATA = 0;
  localparam int BUS_FIELD_RD_ACK  = 32;
  localparam int BUS_FIELD_WR_ACK  = 33;
  localparam int BUS_OUT_WIDTH     = 34;

  localparam logic [7:0] DBG_OP_WR = 8'h57;
  localparam logic [7:0] DBG_OP_RD = 8'h52;
  localparam logic [7:0] DBG_ACK   = 8'h06;
  localparam logic [7:0] DBG_NAK   = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2,
    ST_REQ   = 3'd3,
    ST_ISSUE = 3'd4,
    ST_WAIT  = 3'd5,
    ST_RESP  = 3'd6
  } dbg_state_t;

  // Big-endian accumulation of a received byte into a 32-bit field
  function automatic logic [31:0] shift_in(input logic [31:0] word, input logic [7:0] b);
    return {word[23:0], b};
  endfunction

endpackage

// File: rtl/bus_dbg_master.sv
// Serial debug bus initiator: parses 'W'/'R' byte commands from a UART byte
// stream, performs one 32-bit bus access and streams the reply bytes back.
module bus_dbg_master
  import bus_dbg_master_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int TW      = 11
) (
  input  logic                     clk,
  input  logic                     reset_l,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     bus_req,
  input  logic                     bus_gnt,
  output logic [BUS_IN_WIDTH-1:0]  bus_in,
  input  logic [BUS_OUT_WIDTH-1:0] bus_out,
  output logic                     busy
);

  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);

  dbg_state_t    state;
  logic [31:0]   addr;
  logic [31:0]   wdata;
  logic [31:0]   rsp_sh;
  logic [1:0]    cnt;
  logic          is_wr;
  logic          re;
  logic          we;
  logic [TW-1:0] tmr;

  logic        rx_fire;
  logic        tx_fire;
  logic        ack;
  logic [31:0] rd_data;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign ack     = bus_out[BUS_FIELD_RD_ACK] | bus_out[BUS_FIELD_WR_ACK];
  assign rd_data = bus_out[BUS_FIELD_RD_DATA +: BUS_DATA_W];
  assign busy    = (state != ST_IDLE);

  always_comb begin
    bus_in                                  = '0;
    bus_in[BUS_FIELD_CLK]                   = clk;
    bus_in[BUS_FIELD_RESET_L]               = reset_l;
    bus_in[BUS_FIELD_ADDR +: BUS_ADDR_W]    = addr;
    bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_W] = wdata;
    bus_in[BUS_FIELD_BE +: BUS_BE_W]        = '1;
    bus_in[BUS_FIELD_RE]                    = re;
    bus_in[BUS_FIELD_WE]                    = we;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state    <= ST_IDLE;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
      bus_req  <= 1'b0;
      re       <= 1'b0;
      we       <= 1'b0;
      addr     <= 32'h0;
      wdata    <= 32'h0;
      rsp_sh   <= 32'h0;
      cnt      <= 2'd0;
      is_wr    <= 1'b0;
      tmr      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          rx_ready <= 1'b1;
          if (rx_fire) begin
            cnt <= 2'd0;
            if (rx_data == DBG_OP_WR || rx_data == DBG_OP_RD) begin
              is_wr <= (rx_data == DBG_OP_WR);
              state <= ST_ADDR;
            end else begin
              rx_ready <= 1'b0;
              tx_valid <= 1'b1;
              tx_data  <= DBG_NAK;
              state    <= ST_RESP;
            end
          end
        end
        ST_ADDR, ST_DATA: begin
          if (rx_fire) begin
            if (state == ST_ADDR) addr <= shift_in(addr, rx_data);
            else                  wdata <= shift_in(wdata, rx_data);
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) begin
              if (state == ST_ADDR && is_wr) begin
                state <= ST_DATA;
              end else begin
                rx_ready <= 1'b0;
                bus_req  <= 1'b1;
                state    <= ST_REQ;
              end
            end
          end
        end
        // Grant seen: strobe goes out on the very next cycle
        ST_REQ: begin
          if (bus_gnt) begin
            re    <= ~is_wr;
            we    <= is_wr;
            tmr   <= TMR_LOAD;
            state <= ST_ISSUE;
          end
        end
        // A zero-wait responder may ack during ISSUE; ack beats timeout expiry
        ST_ISSUE, ST_WAIT: begin
          re <= 1'b0;
          we <= 1'b0;
          if (ack) begin
            tx_valid <= 1'b1;
            state    <= ST_RESP;
            if (is_wr) begin
              tx_data <= DBG_ACK;
              cnt     <= 2'd0;
            end else begin
              tx_data <= rd_data[31:24];
              rsp_sh  <= {rd_data[23:0], 8'h00};
              cnt     <= 2'd3;
            end
          end else if (state == ST_ISSUE) begin
            state <= ST_WAIT;
          end else if (tmr == '0) begin
            tx_valid <= 1'b1;
            tx_data  <= DBG_NAK;
            cnt      <= 2'd0;
            state    <= ST_RESP;
          end else begin
            tmr <= tmr - TW'(1);
          end
        end
        // cnt holds the number of bytes still to send after the current one
        ST_RESP: begin
          if (tx_fire) begin
            if (cnt == 2'd0) begin
              tx_valid <= 1'b0;
              bus_req  <= 1'b0;
              rx_ready <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              tx_data <= rsp_sh[31:24];
              rsp_sh  <= {rsp_sh[23:0], 8'h00};
              cnt     <= cnt - 2'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The arbiter must keep the grant for as long as the bus is requested
  a_gnt_held: assert property (@(posedge clk) disable iff (!reset_l)
    (bus_req && (state inside {ST_ISSUE, ST_WAIT, ST_RESP})) |-> bus_gnt);

endmodule

// File: tb/tb_bus_dbg_master.sv
// Scoreboard bench for bus_dbg_master: random debug commands against a memory
// model, with a randomized arbiter, responder and UART transmitter.
module tb_bus_dbg_master;
  import bus_dbg_master_pkg::*;

  localparam int TIMEOUT = 20;
  localparam int TW      = 5;

  logic                     clk;
  logic                     reset_l;
  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     rx_ready;
  logic [7:0]               tx_data;
  logic                     tx_valid;
  logic                     tx_ready;
  logic                     bus_req;
  logic                     bus_gnt;
  logic [BUS_IN_WIDTH-1:0]  bus_in;
  logic [BUS_OUT_WIDTH-1:0] bus_out;
  logic                     busy;

  bus_dbg_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset_l(reset_l),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_req(bus_req), .bus_gnt(bus_gnt),
    .bus_in(bus_in), .bus_out(bus_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        b_re, b_we;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  assign b_re    = bus_in[BUS_FIELD_RE];
  assign b_we    = bus_in[BUS_FIELD_WE];
  assign b_addr  = bus_in[BUS_FIELD_ADDR +: 32];
  assign b_wdata = bus_in[BUS_FIELD_WR_DATA +: 32];
  assign b_be    = bus_in[BUS_FIELD_BE +: 4];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          dly;
  } bus_op_t;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_tx_q[$];
  bus_op_t     exp_bus_q[$];
  int          lat_q[$];
  int          gnt_q[$];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] rsp_mem[logic [31:0]];
  int          tx_mode = 0;
  int          gnt_cyc = 0;
  int          strobe_cyc = 0;
  int          want_dly = 0;
  logic        armed = 1'b0;
  logic        rsp_pend = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0001_0004) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
  endfunction

  function automatic logic has_rsp(input logic [31:0] a);
    return a[31:24] != 8'h0F;
  endfunction

  // Arbiter: grants after a per-request delay, holds grant while requested
  initial begin
    int cnt;
    int dly;
    logic active;
    bus_gnt = 1'b0;
    active  = 1'b0;
    cnt     = 0;
    dly     = 0;
    forever begin
      @(negedge clk);
      if (!bus_req) begin
        bus_gnt = 1'b0;
        active  = 1'b0;
      end else if (!bus_gnt) begin
        if (!active) begin
          active = 1'b1;
          cnt    = 0;
          checks++;
          if (gnt_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_bus_req actual=1 expected=0 (t=%0t)", $time);
            dly = 0;
          end else begin
            dly = gnt_q.pop_front();
          end
        end
        if (cnt >= dly) begin
          bus_gnt = 1'b1;
          gnt_cyc = cyc;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Responder: memory behind every address whose top byte is not 0x0F
  initial begin
    int          cd;
    int          l;
    logic        p_we;
    logic [31:0] p_addr;
    cd = 0; p_we = 1'b0; p_addr = '0;
    bus_out = '0;
    forever begin
      @(negedge clk);
      bus_out = '0;
      if (b_re || b_we) begin
        l = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
        if (has_rsp(b_addr)) begin
          rsp_pend = 1'b1;
          cd       = l;
          p_we     = b_we;
          p_addr   = b_addr;
          if (b_we) rsp_mem[b_addr] = b_wdata;
        end
      end
      if (rsp_pend) begin
        if (cd == 0) begin
          rsp_pend = 1'b0;
          if (p_we) begin
            bus_out[BUS_FIELD_WR_ACK] = 1'b1;
          end else begin
            bus_out[BUS_FIELD_RD_ACK] = 1'b1;
            bus_out[BUS_FIELD_RD_DATA +: 32] =
              rsp_mem.exists(p_addr) ? rsp_mem[p_addr] : init_word(p_addr);
          end
        end else begin
          cd--;
        end
      end else if (!bus_req && $urandom_range(0, 7) == 0) begin
        bus_out[BUS_FIELD_RD_ACK] = 1'b1;
        bus_out[BUS_FIELD_WR_ACK] = 1'($urandom_range(0, 1));
        bus_out[BUS_FIELD_RD_DATA +: 32] = $urandom;
      end
    end
  end

  // Monitor: strobes, reply bytes, latencies and handshake invariants
  initial begin
    bus_op_t op;
    logic    prev_busy;
    logic    rdy;
    prev_busy = 1'b0;
    tx_ready  = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_l) begin
        if (b_re || b_we) begin
          if (exp_bus_q.size() == 0) begin
            chk("unexpected_strobe", {b_re, b_we}, 2'b00);
          end else begin
            op = exp_bus_q.pop_front();
            chk("strobe_we", b_we, op.we);
            chk("strobe_re", b_re, !op.we);
            chk("bus_addr", b_addr, op.addr);
            if (op.we) chk("bus_wdata", b_wdata, op.data);
            chk("bus_be", b_be, 4'hF);
            chk("gnt_to_strobe", cyc - gnt_cyc, 1);
            strobe_cyc = cyc;
            want_dly   = op.dly;
            armed      = 1'b1;
          end
        end
        if (tx_valid && armed) begin
          chk("resp_latency", cyc - strobe_cyc, want_dly);
          armed = 1'b0;
        end
        case (tx_mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom_range(0, 1));
          default: rdy = (cyc % 3 == 0);
        endcase
        tx_ready = rdy;
        if (tx_valid) chk("rx_ready_stalled", rx_ready, 1'b0);
        if (tx_valid && rdy) begin
          if (exp_tx_q.size() == 0) chk("unexpected_tx", tx_data, 8'hxx);
          else chk("tx_byte", tx_data, exp_tx_q.pop_front());
        end
        if (prev_busy && !busy) chk("bus_req_drop", bus_req, 1'b0);
      end
      prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk("rx_ready_timeout", 0, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  function automatic logic acked(input logic [31:0] a, input int lat);
    return has_rsp(a) && lat <= TIMEOUT;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input int gd);
    bus_op_t op;
    op.we = 1'b1; op.addr = a; op.data = d;
    op.dly = acked(a, lat) ? lat + 1 : TIMEOUT + 1;
    exp_bus_q.push_back(op);
    gnt_q.push_back(gd);
    lat_q.push_back(lat);
    if (has_rsp(a)) ref_mem[a] = d;
    exp_tx_q.push_back(acked(a, lat) ? DBG_ACK : DBG_NAK);
    send_byte(DBG_OP_WR);
    send_word(a);
    send_word(d);
  endtask

  task automatic do_read(input logic [31:0] a, input int lat, input int gd);
    bus_op_t     op;
    logic [31:0] w;
    op.we = 1'b0; op.addr = a; op.data = '0;
    op.dly = acked(a, lat) ? lat + 1 : TIMEOUT + 1;
    exp_bus_q.push_back(op);
    gnt_q.push_back(gd);
    lat_q.push_back(lat);
    if (acked(a, lat)) begin
      w = ref_mem.exists(a) ? ref_mem[a] : init_word(a);
      for (int i = 3; i >= 0; i--) exp_tx_q.push_back(w[8*i +: 8]);
    end else begin
      exp_tx_q.push_back(DBG_NAK);
    end
    send_byte(DBG_OP_RD);
    send_word(a);
  endtask

  task automatic do_bad(input logic [7:0] op);
    exp_tx_q.push_back(DBG_NAK);
    send_byte(op);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_tx_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) chk("drain_timeout", exp_tx_q.size(), 0);
  endtask

  task automatic pulse_reset(input string tag);
    #2 reset_l = 1'b0;
    #1;
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_bus_req"}, bus_req, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_strobes"}, {b_re, b_we}, 2'b00);
    exp_tx_q.delete();
    exp_bus_q.delete();
    lat_q.delete();
    gnt_q.delete();
    armed    = 1'b0;
    rsp_pend = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_l = 1'b1;
    @(negedge clk);
    chk({tag, "_rx_ready_after"}, rx_ready, 1'b1);
  endtask

  initial begin
    int          kind;
    int          lat;
    int          gd;
    logic [31:0] a;
    logic [7:0]  bad;
    logic [7:0]  top_sel[3];
    top_sel[0] = 8'h00; top_sel[1] = 8'h02; top_sel[2] = 8'h0F;
    reset_l  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rx_ready", rx_ready, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {b_re, b_we}, 2'b00);
    chk("rst_addr", b_addr, 32'h0);
    chk("rst_wdata", b_wdata, 32'h0);
    reset_l = 1'b1;
    @(negedge clk);
    chk("rx_ready_first_clk", rx_ready, 1'b1);

    do_write(32'h0200_0000, 32'h0000_00A5, 1, 0);
    do_read(32'h0200_0000, 2, 0);
    do_read(32'h0001_0004, 0, 1);
    do_read(32'h0F00_0000, 0, 0);
    do_bad(8'h41);
    do_read(32'h0001_0004, 1, 0);
    drain();

    tx_mode = 2;
    do_read(32'h0000_0101, TIMEOUT, 50);
    do_write(32'h0200_0013, 32'h1234_5678, TIMEOUT + 1, 3);
    do_read(32'h0200_0013, 0, 50);
    drain();

    for (int k = 0; k < 40; k++) begin
      tx_mode = $urandom_range(0, 2);
      kind    = $urandom_range(0, 9);
      a       = {top_sel[$urandom_range(0, 2)], 16'h0000, 8'($urandom_range(0, 15))};
      case ($urandom_range(0, 7))
        0, 1, 2: lat = $urandom_range(0, 3);
        3:       lat = TIMEOUT;
        4:       lat = TIMEOUT + 1;
        default: lat = $urandom_range(0, TIMEOUT);
      endcase
      gd = ($urandom_range(0, 9) == 0) ? 50 : $urandom_range(0, 4);
      if (kind < 4) begin
        do_write(a, $urandom, lat, gd);
      end else if (kind < 8) begin
        do_read(a, lat, gd);
      end else begin
        bad = 8'($urandom);
        if (bad == DBG_OP_WR || bad == DBG_OP_RD) bad = 8'h00;
        do_bad(bad);
      end
    end
    drain();
    tx_mode = 0;

    send_byte(DBG_OP_WR);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h00);
    pulse_reset("rst_addr_phase");
    do_write(32'h0200_0004, 32'hCAFE_0001, 1, 0);
    drain();

    begin
      bus_op_t op;
      int      n = 0;
      op.we = 1'b0; op.addr = 32'h0F00_0010; op.data = '0; op.dly = TIMEOUT + 1;
      exp_bus_q.push_back(op);
      gnt_q.push_back(0);
      lat_q.push_back(0);
      send_byte(DBG_OP_RD);
      send_word(32'h0F00_0010);
      while (!bus_gnt && n < 200) begin
        @(negedge clk);
        n++;
      end
      repeat (5) @(negedge clk);
      chk("wait_bus_req", bus_req, 1'b1);
      pulse_reset("rst_wait_phase");
    end
    do_write(32'h0200_0008, 32'h0BAD_F00D, 0, 2);
    do_read(32'h0200_0008, 1, 0);
    drain();
    repeat (5) @(negedge clk);
    chk("tx_queue_empty", exp_tx_q.size(), 0);
    chk("bus_queue_empty", exp_bus_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
